// File: rtl/bcd_to_onehot_dec.sv
// BCD digit to one-hot decimal decoder behind a 2-entry FIFO.
// Invalid codes (10..15) are tracked by a saturating error counter.
module bcd_to_onehot_dec #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           bcd_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [9:0]           dec_out,
    output logic                 dec_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clr_err
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid must not depend on ready, and the payload is held until taken.

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [1:0]           count_q;
    logic [10:0]          head_q;
    logic [10:0]          tail_q;
    logic                 ready_en_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [10:0]          new_entry;
    logic                 code_invalid;
    logic                 push;
    logic                 pop;

    // Entry layout: bit 10 is the error flag, bits 9:0 the one-hot digit.
    always_comb begin
        new_entry    = '0;
        code_invalid = (bcd_in > 4'd9);
        if (code_invalid) begin
            new_entry[10] = 1'b1;
        end else begin
            new_entry[9:0] = 10'd1 << bcd_in;
        end
    end

    assign in_ready  = ready_en_q && (count_q != CNT_FULL);
    assign out_valid = (count_q != CNT_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign dec_out   = out_valid ? head_q[9:0] : 10'd0;
    assign dec_err   = out_valid ? head_q[10] : 1'b0;
    assign err_count = err_cnt_q;

    // ready_en_q keeps in_ready low through reset and its release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (push) begin
                        head_q  <= new_entry;
                        count_q <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        head_q <= new_entry;
                    end else if (push) begin
                        tail_q  <= new_entry;
                        count_q <= CNT_FULL;
                    end else if (pop) begin
                        count_q <= CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    // No push is possible when full, so only a pop moves state.
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= CNT_ONE;
                    end
                end
                default: begin
                    count_q <= CNT_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clr_err) begin
            err_cnt_q <= '0;
        end else if (push && code_invalid && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

endmodule
